// File: rtl/if_fetch_pkg.sv
// Shared constants, bus widths and FSM encoding for the byte-serial instruction fetch unit.
package if_fetch_pkg;

    localparam logic RstEnable      = 1'b1;
    localparam int   InstAddrBus    = 32;
    localparam int   InstBus        = 32;
    localparam int   ICACHE_ENTRIES = 16;
    localparam int   ICACHE_INDEX_W = 4;
    localparam int   ICACHE_TAG_W   = InstAddrBus - ICACHE_INDEX_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache with a combinational lookup port and a single-word fill port.
// Only compiled into if_fetch when ICACHE_EN is defined.
module if_icache
    import if_fetch_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ICACHE_INDEX_W-1:0] lookup_index,
    input  logic [ICACHE_TAG_W-1:0]   lookup_tag,
    output logic                      hit,
    output logic [InstBus-1:0]        rdata,
    input  logic                      fill_en,
    input  logic [ICACHE_INDEX_W-1:0] fill_index,
    input  logic [ICACHE_TAG_W-1:0]   fill_tag,
    input  logic [InstBus-1:0]        fill_data
);

    logic [ICACHE_ENTRIES-1:0] valid_q;
    logic [ICACHE_TAG_W-1:0]   tag_q  [ICACHE_ENTRIES];
    logic [InstBus-1:0]        data_q [ICACHE_ENTRIES];

    assign hit   = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);
    assign rdata = data_q[lookup_index];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_index] <= 1'b1;
        end
    end

    // NOTE: tag/data storage is deliberately not reset; the valid bits alone decide whether an entry is used.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= fill_data;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch over an arbitrated 8-bit memory port, assembling little-endian 32-bit words.
// Optional feature: define ICACHE_EN to add a 16-entry direct-mapped instruction cache (if_icache).
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pc_branch_i,
    input  logic [InstAddrBus-1:0] branch_addr_i,
    input  logic                   stall_i,
    input  logic                   mem_grant_i,
    input  logic [7:0]             mem_din_i,
    output logic                   mem_rd_o,
    output logic [InstAddrBus-1:0] mem_addr_o,
    output logic [InstBus-1:0]     inst_o,
    output logic [InstAddrBus-1:0] inst_pc_o,
    output logic                   inst_valid_o
);

    fetch_state_e           state_q, state_d;
    logic [InstAddrBus-1:0] pc_q;
    logic [2:0]             cnt_q;
    logic                   pend_q;
    logic [1:0]             lane_q;
    logic [InstBus-1:0]     inst_q;
    logic [InstAddrBus-1:0] inst_pc_q;

    logic               cache_hit;
    logic [InstBus-1:0] cache_data;
    logic               use_hit;
    logic               last_capture;

`ifdef ICACHE_EN
    logic fill_en;

    // The last byte is still on mem_din_i, so the fill word is spliced here rather than read from inst_q.
    assign fill_en = (state_q == ST_FETCH) && last_capture && !pc_branch_i;

    if_icache u_icache (
        .clk          (clk),
        .rst          (rst),
        .lookup_index (pc_q[ICACHE_INDEX_W+1:2]),
        .lookup_tag   (pc_q[InstAddrBus-1:ICACHE_INDEX_W+2]),
        .hit          (cache_hit),
        .rdata        (cache_data),
        .fill_en      (fill_en),
        .fill_index   (pc_q[ICACHE_INDEX_W+1:2]),
        .fill_tag     (pc_q[InstAddrBus-1:ICACHE_INDEX_W+2]),
        .fill_data    ({mem_din_i, inst_q[23:0]})
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    // A lookup is only meaningful before the first byte of this word has been requested.
    assign use_hit      = (state_q == ST_FETCH) && (cnt_q == 3'd0) && !pend_q && cache_hit;
    assign last_capture = pend_q && (lane_q == 2'd3);

    assign mem_rd_o     = (state_q == ST_FETCH) && (cnt_q < 3'd4) && !pc_branch_i && !use_hit;
    assign mem_addr_o   = pc_q + {29'd0, cnt_q};
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = (state_q == ST_HOLD);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (use_hit || last_capture) state_d = ST_HOLD;
            ST_HOLD:  if (!stall_i) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
        if (pc_branch_i) state_d = ST_FETCH;
    end

    // NOTE: state is updated with non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            lane_q    <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= mem_rd_o && mem_grant_i;
            lane_q  <= cnt_q[1:0];
            if (pc_branch_i) begin
                // Redirect wins over stall and consumption; any byte in flight is dropped.
                pc_q   <= branch_addr_i & ~32'h3;
                cnt_q  <= '0;
                pend_q <= 1'b0;
            end else begin
                if (mem_rd_o && mem_grant_i) cnt_q <= cnt_q + 3'd1;
                if (pend_q) inst_q[{lane_q, 3'b000} +: 8] <= mem_din_i;
                if (use_hit) inst_q <= cache_data;
                if ((state_q == ST_FETCH) && (state_d == ST_HOLD)) inst_pc_q <= pc_q;
                if ((state_q == ST_HOLD) && !stall_i) begin
                    pc_q  <= pc_q + 32'd4;
                    cnt_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: reset/fetch vector table, directed corner sequences and a
// randomized run checked against an instruction-stream model (pc progression plus memory contents).
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst, pc_branch_i, stall_i, mem_grant_i;
    logic [31:0] branch_addr_i;
    logic [7:0]  mem_din_i;
    logic        mem_rd_o, inst_valid_o;
    logic [31:0] mem_addr_o, inst_o, inst_pc_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [1024];

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .pc_branch_i   (pc_branch_i),
        .branch_addr_i (branch_addr_i),
        .stall_i       (stall_i),
        .mem_grant_i   (mem_grant_i),
        .mem_din_i     (mem_din_i),
        .mem_rd_o      (mem_rd_o),
        .mem_addr_o    (mem_addr_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_valid_o  (inst_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, s, chk, chk_addr, chk_word, rd;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] inst, ipc;
    } vec_t;

    function automatic vec_t mk(input logic r, s, chk, ca, cw, rd, input logic [31:0] addr,
                                input logic valid, input logic [31:0] inst, ipc);
        vec_t v;
        v.r = r; v.s = s; v.chk = chk; v.chk_addr = ca; v.chk_word = cw; v.rd = rd;
        v.addr = addr; v.valid = valid; v.inst = inst; v.ipc = ipc;
        return v;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [9:0] i;
        i = a[9:0];
        return {mem[i + 10'd3], mem[i + 10'd2], mem[i + 10'd1], mem[i]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic set_in(input logic r, b, input logic [31:0] ba, input logic s, g);
        rst = r; pc_branch_i = b; branch_addr_i = ba; stall_i = s; mem_grant_i = g;
        #1;
    endtask

    // Memory model: a granted request returns its byte in the following cycle; otherwise garbage.
    task automatic cycle();
        logic [7:0] nd;
        nd = (mem_rd_o && mem_grant_i) ? mem[mem_addr_o[9:0]] : 8'($urandom);
        @(posedge clk);
        #1 mem_din_i = nd;
        @(negedge clk);
    endtask

    // Runs from the current cycle until inst_valid_o; grant is withheld for gap_len cycles from gap_at.
    task automatic run_fetch(input int gap_at, input int gap_len, output int lat);
        lat = 0;
        do begin
            set_in(1'b0, 1'b0, 32'd0, 1'b0, !(lat >= gap_at && lat < gap_at + gap_len));
            cycle();
            lat++;
        end while (!inst_valid_o && lat < 20);
    endtask

    vec_t vecs[13];
    int   lat;
    int   consumed;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc, off, r_ba;
        logic        r_rst, r_br, r_st, r_gr, hold_prev, clear_prev;

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;
        mem_din_i = 8'h00;
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        @(negedge clk);

        // r s chk ca cw rd addr valid inst ipc
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd1, 1'b0, 32'd0, 32'd0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd2, 1'b0, 32'd0, 32'd0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd3, 1'b0, 32'd0, 32'd0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        vecs[8]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h513, 32'd0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h513, 32'd0);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h513, 32'd0);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h513, 32'd0);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd4, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].r, 1'b0, 32'd0, vecs[i].s, 1'b1);
            if (vecs[i].chk) begin
                check_bit($sformatf("vec%0d mem_rd", i), mem_rd_o, vecs[i].rd);
                check_bit($sformatf("vec%0d valid", i), inst_valid_o, vecs[i].valid);
                if (vecs[i].chk_addr) check($sformatf("vec%0d addr", i), mem_addr_o, vecs[i].addr);
                if (vecs[i].chk_word) begin
                    check($sformatf("vec%0d inst", i), inst_o, vecs[i].inst);
                    check($sformatf("vec%0d inst_pc", i), inst_pc_o, vecs[i].ipc);
                end
            end
            cycle();
        end

        // Redirect to 0x107 while the word at 4 is at counter 2.
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        check("pre-redirect addr", mem_addr_o, 32'd5);
        cycle();
        set_in(1'b0, 1'b1, 32'h107, 1'b0, 1'b1);
        check_bit("redirect cycle mem_rd", mem_rd_o, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        check_bit("after redirect valid", inst_valid_o, 1'b0);
        check("after redirect addr", mem_addr_o, 32'h104);
        run_fetch(0, 0, lat);
        check("redirect fetch latency", 32'(lat), 32'd5);
        check("redirect inst_pc", inst_pc_o, 32'h104);
        check("redirect inst", inst_o, word_at(32'h104));

        // Consume, then withhold grant for two cycles mid-word.
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle();
        check_bit("valid drops after consume", inst_valid_o, 1'b0);
        run_fetch(2, 2, lat);
        check("grant gap latency", 32'(lat), 32'd7);
        check("grant gap inst_pc", inst_pc_o, 32'h108);
        check("grant gap inst", inst_o, word_at(32'h108));

        // Redirect beats stall; unaligned target is aligned; then pc wraps past 0xFFFFFFFC.
        set_in(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        check_bit("redirect over stall mem_rd", mem_rd_o, 1'b0);
        cycle();
        check_bit("redirect over stall valid", inst_valid_o, 1'b0);
        run_fetch(0, 0, lat);
        check("top word latency", 32'(lat), 32'd5);
        check("top word inst_pc", inst_pc_o, 32'hFFFF_FFFC);
        check("top word inst", inst_o, word_at(32'hFFFF_FFFC));
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle();
        run_fetch(0, 0, lat);
        check("wrap inst_pc", inst_pc_o, 32'd0);
        check("wrap inst", inst_o, 32'h0000_0513);

        // Reset mid-fetch, asserted together with a redirect.
        set_in(1'b0, 1'b1, 32'h300, 1'b0, 1'b1);
        cycle();
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle();
        cycle();
        set_in(1'b1, 1'b1, 32'h200, 1'b0, 1'b1);
        cycle();
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        check_bit("mid-fetch reset mem_rd", mem_rd_o, 1'b0);
        check_bit("mid-fetch reset valid", inst_valid_o, 1'b0);
        check("mid-fetch reset addr", mem_addr_o, 32'd0);
        check("mid-fetch reset inst", inst_o, 32'd0);
        check("mid-fetch reset inst_pc", inst_pc_o, 32'd0);
        run_fetch(0, 0, lat);
        check("post-reset latency incl idle", 32'(lat), 32'd6);
        check("post-reset inst_pc", inst_pc_o, 32'd0);
        check("post-reset inst", inst_o, 32'h0000_0513);

`ifdef ICACHE_EN
        set_in(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
        cycle();
        run_fetch(0, 0, lat);
        check("cache miss latency", 32'(lat), 32'd5);
        set_in(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
        cycle();
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        check_bit("cache hit mem_rd", mem_rd_o, 1'b0);
        cycle();
        check_bit("cache hit valid", inst_valid_o, 1'b1);
        check("cache hit inst_pc", inst_pc_o, 32'h40);
        check("cache hit inst", inst_o, word_at(32'h40));
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle();
        set_in(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
        cycle();
        run_fetch(0, 0, lat);
        check("cache cleared by reset latency", 32'(lat), 32'd5);
        check("cache cleared inst", inst_o, word_at(32'h40));
`endif

        // Randomized run against the instruction-stream model.
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle();
        exp_pc = 32'd0; hold_prev = 1'b0; clear_prev = 1'b1; consumed = 0;
        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            r_br  = ($urandom_range(0, 15) == 0);
            r_ba  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1023));
            r_st  = ($urandom_range(0, 2) == 0);
            r_gr  = ($urandom_range(0, 3) != 0);
            set_in(r_rst, r_br, r_ba, r_st, r_gr);
            if (hold_prev)  check_bit("rand held valid", inst_valid_o, 1'b1);
            if (clear_prev) check_bit("rand cleared valid", inst_valid_o, 1'b0);
            if (inst_valid_o) begin
                check("rand inst_pc", inst_pc_o, exp_pc);
                check("rand inst", inst_o, word_at(exp_pc));
            end
            if (mem_rd_o) begin
                off = mem_addr_o - exp_pc;
                check_bit("rand addr within word", off < 32'd4, 1'b1);
                check_bit("rand no read while valid", inst_valid_o, 1'b0);
            end
            if (r_br) check_bit("rand redirect mem_rd", mem_rd_o, 1'b0);
            hold_prev  = !r_rst && !r_br && inst_valid_o && r_st;
            clear_prev = r_rst || r_br || (inst_valid_o && !r_st);
            if (r_rst) exp_pc = 32'd0;
            else if (r_br) exp_pc = r_ba & ~32'h3;
            else if (inst_valid_o && !r_st) begin
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            cycle();
        end
        check_bit("rand progress", consumed > 50, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
